// File: rtl/sa_result_writer.sv
// Write-back engine: buffers one N-lane result vector per handshake and writes it word by word
// into a scratchpad write port. Optional build macro: SA_WB_RELU_EN (clamp negative lanes to zero at capture).
module sa_result_writer #(
   parameter int N  = 4,
   parameter int AW = 6,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          y_valid_i,
   output logic          y_ready_o,
   input  logic [DW-1:0] y_in [N],
   input  logic [AW-1:0] base_addr_i,
   output logic          spad_csb0,
   output logic          spad_web0,
   output logic [AW-1:0] spad_addr0,
   output logic [DW-1:0] spad_din0,
   output logic          busy_o,
   output logic          done_o
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   typedef enum logic [1:0] {IDLE, WR, DONE} state_t;

   state_t          st;
   state_t          st_nxt;
   logic            pend_valid;
   logic [DW-1:0]   pend_data [N];
   logic [AW-1:0]   pend_base;
   logic [DW-1:0]   active [N];
   logic [AW-1:0]   active_base;
   logic [IW-1:0]   idx;
   logic [IW-1:0]   idx_nxt;
   logic            consume;
   logic            accept;

   function automatic logic [DW-1:0] relu(input logic [DW-1:0] w);
`ifdef SA_WB_RELU_EN
      return w[DW-1] ? '0 : w;
`else
      return w;
`endif
   endfunction

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) st <= IDLE;
      else     st <= st_nxt;
   end

   // Next-state logic
   always_comb begin
      st_nxt = st;
      case (st)
         IDLE:    if (pend_valid) st_nxt = WR;
         WR:      if (idx == LAST) st_nxt = DONE;
         DONE:    st_nxt = pend_valid ? WR : IDLE;
         default: st_nxt = IDLE;
      endcase
   end

   // Output / handshake decode, all from registered state
   always_comb begin
      consume   = pend_valid && (st == IDLE || st == DONE);
      y_ready_o = !pend_valid || consume;
      accept    = y_valid_i && y_ready_o;
      busy_o    = pend_valid || (st != IDLE);
      done_o    = (st == DONE);
      idx_nxt   = idx + IW'(1);
   end

   // Port0 is fully registered so the first word is presented in the cycle the active slot loads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_valid  <= 1'b0;
         pend_base   <= '0;
         active_base <= '0;
         idx         <= '0;
         spad_csb0   <= 1'b1;
         spad_web0   <= 1'b1;
         spad_addr0  <= '0;
         spad_din0   <= '0;
         for (int i = 0; i < N; i++) begin
            pend_data[i] <= '0;
            active[i]    <= '0;
         end
      end else begin
         if (accept) begin
            pend_valid <= 1'b1;
            pend_base  <= base_addr_i;
            for (int i = 0; i < N; i++) pend_data[i] <= relu(y_in[i]);
         end else if (consume) begin
            pend_valid <= 1'b0;
         end

         if (consume) begin
            active_base <= pend_base;
            for (int i = 0; i < N; i++) active[i] <= pend_data[i];
            idx        <= '0;
            spad_addr0 <= pend_base;
            spad_din0  <= pend_data[0];
         end else if (st == WR && idx != LAST) begin
            idx        <= idx_nxt;
            spad_addr0 <= active_base + AW'(idx_nxt);
            spad_din0  <= active[idx_nxt];
         end

         spad_csb0 <= (st_nxt != WR);
         spad_web0 <= (st_nxt != WR);
      end
   end

endmodule

// File: doc/sa_result_writer.md
# sa_result_writer

Write-back engine for systolic-array results. It accepts one N-lane FP32 result vector per valid/ready handshake and buffers it. It then writes the N words sequentially into a result scratchpad through an OpenRAM-style write port (port0) at a caller-supplied base address. It sits downstream of the systolic array's `y_out`, so it mirrors the loader that reads operand scratchpads.

## Interface
- `N`, 4, number of lanes = words written per vector
- `AW`, 6, scratchpad address width (depth 2^AW)
- `DW`, 32, word width (FP32 bit pattern, `word_t`)

- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `y_valid_i`  in  1  result vector present
- `y_ready_o`  out  1  vector accepted on an edge where `y_valid_i && y_ready_o`
- `y_in[N-1:0]`  in  DW each (unpacked)  result lanes, lane 0 written first
- `base_addr_i`  in  AW  destination address of lane 0, sampled with the vector
- `spad_csb0`  out  1  scratchpad chip select, active-low
- `spad_web0`  out  1  scratchpad write enable, active-low
- `spad_addr0`  out  AW  write address
- `spad_din0`  out  DW  write data
- `busy_o`  out  1  a vector is pending or being written
- `done_o`  out  1  one-cycle pulse after the last word of a vector is written

## Operation
- Storage: one pending slot (`pend_*`: valid, N words, base) and one active slot (N words, base, index `idx`).
- Accept: on a handshake edge, `y_in` and `base_addr_i` are copied into the pending slot and `pend_valid` is set.
- `y_ready_o = !pend_valid || consume`, where `consume = pend_valid && (st == IDLE || st == DONE)`. A vector arriving on the same edge the pending slot is consumed is captured into the pending slot.
- FSM states: IDLE, WR, DONE.
  - IDLE: if `pend_valid`, move pending to active, set `idx = 0`, go to WR.
  - WR: drive `spad_csb0 = 0`, `spad_web0 = 0`, `spad_addr0 = active_base + idx`, `spad_din0 = active[idx]`. Increment `idx` each cycle. After `idx == N-1`, go to DONE.
  - DONE: `done_o = 1`. If `pend_valid`, consume it and go to WR; otherwise go to IDLE.
- Address arithmetic: `active_base + idx` is computed mod 2^AW, so writes wrap (base 62, N=4 gives addresses 62, 63, 0, 1).
- Outside WR, `spad_csb0 = spad_web0 = 1`. `spad_addr0` and `spad_din0` hold their last values.
- `busy_o = pend_valid || st != IDLE`.

## Timing
- Reset values: st = IDLE, `pend_valid = 0`, `idx = 0`, `spad_csb0 = 1`, `spad_web0 = 1`, `spad_addr0 = 0`, `spad_din0 = 0`, `done_o = 0`, `busy_o = 0`, `y_ready_o = 1`.
- All outputs are decoded from registers only; there is no combinational path from `y_valid_i`, `y_in` or `base_addr_i` to any scratchpad output.
- Handshake at edge E0 produces:
  - active load at E1;
  - port0 asserted for cycles E1 to E1+N, so the SRAM captures words at E2 through E1+N;
  - `done_o` high in cycle E1+N to E2+N.
- Sustained throughput is one vector per N+1 cycles. A back-to-back vector starts WR at E2+N with no idle cycle.
- Backpressure: with one vector active and one pending, `y_ready_o = 0` until the DONE cycle.
- Reset mid-operation: port0 deasserts asynchronously and immediately; the partial vector and the pending vector are discarded. No `done_o` is issued for either.
- `base_addr_i` and `y_in` are don't-care when `y_valid_i = 0`.

## Configuration
- `SA_WB_RELU_EN` defined: at capture into the pending slot, any lane with bit DW-1 set (negative, -0.0, or negative-sign NaN) is replaced by `32'h0000_0000`.
- `SA_WB_RELU_EN` undefined: lanes are written bit-exact.
- Timing is identical in both builds.

## Test plan
- Single vector [1.0, 2.0, 3.0, 4.0] at base 8 → writes addr 8/9/10/11 with data `3F800000`/`40000000`/`40400000`/`40800000` on 4 consecutive edges. `done_o` pulses one cycle after the last write. `busy_o` falls afterward.
- Base 62, N=4 → addresses 62, 63, 0, 1 in order.
- Three vectors offered on consecutive cycles:
  - the first two are accepted;
  - `y_ready_o` stays 0 until the first vector's DONE cycle, then the third is accepted;
  - there are 12 writes total, in order, with exactly one non-write cycle (DONE) between vectors.
- Reset asserted after the 2nd write of a vector with one pending → `spad_csb0` and `spad_web0` go high the same cycle. After release, `busy_o = 0`, `y_ready_o = 1`, and no further writes or `done_o` occur.
- Vector [-2.0, 3.0, -0.0, 5.0] at base 0:
  - with `SA_WB_RELU_EN`: data `00000000`, `40400000`, `00000000`, `40A00000`;
  - without it: `C0000000`, `40400000`, `80000000`, `40A00000`.
- `y_valid_i` toggling with random `y_in` while `y_ready_o = 0` → the pending slot contents and the later write data are unchanged.
